instr_fetch: RTL and testbench

Instruction fetch unit: the producer side of the instruction interface that the decode stage consumes.
- Owns the fetch PC and issues single-outstanding requests to instruction memory.
- Buffers the returned 32-bit instruction and presents it to decode with a valid/ready handshake.
- Handles branch redirects, including discarding an in-flight stale response.

---
 rtl/instr_fetch_pkg.sv | 20 ++
 rtl/fetch_pc_reg.sv | 34 +++
 rtl/instr_fetch.sv | 93 +++++++++
 tb/tb_instr_fetch.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared widths, fetch FSM encoding and PC helpers for the instruction fetch unit.
package instr_fetch_pkg;

  localparam int WORD            = 64;
  localparam int INSTR_LEN       = 32;
  localparam int PC_STEP_DEFAULT = 4;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_HOLD  = 2'd2,
    FETCH_FLUSH = 2'd3
  } fetch_state_e;

  // Instructions are word aligned; the low two address bits are always dropped.
  function automatic logic [WORD-1:0] align_word(input logic [WORD-1:0] addr);
    return {addr[WORD-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch PC register: redirect load (with alignment masking) wins over sequential increment.
module fetch_pc_reg
  import instr_fetch_pkg::*;
#(
  parameter logic [WORD-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_redirect,
  input  logic [WORD-1:0] target,
  input  logic            increment,
  output logic [WORD-1:0] fetch_pc,
  output logic            misaligned
);

  localparam logic [WORD-1:0] STEP = WORD'(PC_STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc   <= RESET_PC;
      misaligned <= 1'b0;
    end else begin
      misaligned <= load_redirect && (target[1:0] != 2'b00);
      if (load_redirect) begin
        fetch_pc <= align_word(target);
      end else if (increment) begin
        // Wraps modulo 2^WORD without any flag.
        fetch_pc <= fetch_pc + STEP;
      end
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding imem requests, one-entry instruction
// buffer towards decode, and redirect handling including stale-response flushing.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [WORD-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imem_req,
  output logic [WORD-1:0]      imem_addr,
  input  logic                 imem_ack,
  input  logic [INSTR_LEN-1:0] imem_rdata,
  output logic                 instr_valid,
  output logic [INSTR_LEN-1:0] instruction,
  output logic [WORD-1:0]      pc,
  input  logic                 instr_ready,
  input  logic                 redirect,
  input  logic [WORD-1:0]      redirect_pc,
  output logic                 misaligned,
  output logic [1:0]           fsm_state
);

  // Handshakes: imem_req/imem_addr hold until a cycle with imem_ack=1; decode
  // consumes the buffered instruction on a cycle with instr_valid=1 and instr_ready=1,
  // unless redirect is high in that cycle, in which case the instruction is discarded.

  fetch_state_e    state;
  logic [WORD-1:0] fetch_pc;
  logic [WORD-1:0] stale_addr;
  logic            increment;

  assign increment = (state == FETCH_REQ) && imem_ack && !redirect;
  assign imem_req  = (state == FETCH_REQ) || (state == FETCH_FLUSH);
  assign imem_addr = (state == FETCH_FLUSH) ? stale_addr : fetch_pc;
  assign fsm_state = state;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_fetch_pc_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_redirect (redirect),
    .target        (redirect_pc),
    .increment     (increment),
    .fetch_pc      (fetch_pc),
    .misaligned    (misaligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH_IDLE;
      stale_addr  <= RESET_PC;
      instr_valid <= 1'b0;
      instruction <= '0;
      pc          <= RESET_PC;
    end else begin
      case (state)
        FETCH_IDLE: begin
          state <= FETCH_REQ;
        end
        FETCH_REQ: begin
          if (redirect && !imem_ack) begin
            // Request still open at the old address: close it out in FLUSH.
            stale_addr <= fetch_pc;
            state      <= FETCH_FLUSH;
          end else if (imem_ack && !redirect) begin
            instruction <= imem_rdata;
            pc          <= fetch_pc;
            instr_valid <= 1'b1;
            state       <= FETCH_HOLD;
          end
          // redirect with ack: response dropped, new address issued next cycle.
        end
        FETCH_HOLD: begin
          if (redirect || instr_ready) begin
            instr_valid <= 1'b0;
            state       <= FETCH_REQ;
          end
        end
        FETCH_FLUSH: begin
          if (imem_ack) begin
            state <= FETCH_REQ;
          end
        end
        default: state <= FETCH_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory model with programmable latency,
// scoreboard of expected {pc, instruction} pairs popped on each decode handshake.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [63:0] pc;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        misaligned;
  logic [1:0]  fsm_state;

  instr_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .pc          (pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .misaligned  (misaligned),
    .fsm_state   (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int mem_lat = 0;
  bit mem_stall = 1'b0;
  int mis_cnt = 0;
  logic [95:0] exp_q[$];
  logic [63:0] addr_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [63:0] addr);
    if (addr == 64'h0) return 32'hF800_0020;
    return {16'h1300, addr[15:0]};
  endfunction

  // ---------------- memory model ----------------
  int mem_cnt = 0;
  always begin
    @(negedge clk);
    #1;
    if (!rst_n || !imem_req || mem_stall) begin
      imem_ack = 1'b0;
      mem_cnt  = 0;
    end else if (mem_cnt >= mem_lat) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_data(imem_addr);
      mem_cnt    = 0;
    end else begin
      imem_ack = 1'b0;
      mem_cnt++;
    end
  end

  // Request-side protocol: address stable while a request waits, log of acked addresses.
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [63:0] prev_addr = '0;
  always begin
    @(negedge clk);
    #3;
    if (!rst_n) begin
      prev_req = 1'b0;
    end else begin
      if (prev_req && !prev_ack && imem_req) check("addr_stable", imem_addr, prev_addr);
      if (imem_req && imem_ack) addr_log.push_back(imem_addr);
      prev_req  = imem_req;
      prev_ack  = imem_ack;
      prev_addr = imem_addr;
    end
  end

  // ---------------- scoreboard monitor ----------------
  always begin
    logic [95:0] e;
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (misaligned) mis_cnt++;
      if (instr_valid && instr_ready && !redirect) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL mon_unexpected: got pc %h instr %h expected none", pc, instruction);
        end else begin
          e = exp_q.pop_front();
          check("mon_pc", pc, e[95:32]);
          check("mon_instr", {32'h0, instruction}, {32'h0, e[31:0]});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_instr(input logic [63:0] p, input logic [31:0] i);
    exp_q.push_back({p, i});
  endtask

  task automatic do_reset(input int lat, input logic rdy);
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = rdy;
    mem_lat     = lat;
    mem_stall   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", {63'h0, imem_req}, 64'h0);
    check("rst_addr", imem_addr, 64'h0);
    check("rst_valid", {63'h0, instr_valid}, 64'h0);
    check("rst_instr", {32'h0, instruction}, 64'h0);
    check("rst_pc", pc, 64'h0);
    check("rst_mis", {63'h0, misaligned}, 64'h0);
    exp_q.delete();
    addr_log.delete();
    mis_cnt = 0;
    rst_n   = 1'b1;
  endtask

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #3;
      if (exp_q.size() == 0) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL wait_empty: got %0d pending expected 0", exp_q.size());
    exp_q.delete();
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (instr_valid) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL wait_valid: got instr_valid 0 expected 1 within %0d cycles", budget);
  endtask

  task automatic finish_test();
    wait_empty(40);
    tick();
    instr_ready = 1'b0;
    repeat (3) tick();
    check("queue_empty", 64'(exp_q.size()), 64'h0);
  endtask

  task automatic check_log(input int idx, input logic [63:0] exp);
    if (addr_log.size() > idx) check("addr_log", addr_log[idx], exp);
    else check("addr_log_len", 64'(addr_log.size()), 64'(idx + 1));
  endtask

  // ---------------- tests ----------------
  initial begin
    // Zero-wait memory, decode always ready.
    do_reset(0, 1'b1);
    expect_instr(64'h0, 32'hF800_0020);
    expect_instr(64'h4, 32'h1300_0004);
    expect_instr(64'h8, 32'h1300_0008);
    tick();
    check("t1_req_c1", {63'h0, imem_req}, 64'h1);
    check("t1_addr_c1", imem_addr, 64'h0);
    check("t1_valid_c1", {63'h0, instr_valid}, 64'h0);
    tick();
    check("t1_valid_c2", {63'h0, instr_valid}, 64'h1);
    check("t1_pc_c2", pc, 64'h0);
    tick();
    check("t1_req_c3", {63'h0, imem_req}, 64'h1);
    check("t1_addr_c3", imem_addr, 64'h4);
    finish_test();

    // 3-cycle memory, decode stalls for 5 cycles.
    do_reset(3, 1'b0);
    expect_instr(64'h0, 32'hF800_0020);
    wait_valid(20);
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", {63'h0, instr_valid}, 64'h1);
      check("t2_hold_pc", pc, 64'h0);
      check("t2_hold_instr", {32'h0, instruction}, 64'hF800_0020);
      check("t2_hold_req", {63'h0, imem_req}, 64'h0);
      tick();
    end
    instr_ready = 1'b1;
    expect_instr(64'h4, 32'h1300_0004);
    tick();
    check("t2_next_req", {63'h0, imem_req}, 64'h1);
    check("t2_next_addr", imem_addr, 64'h4);
    finish_test();
    check_log(0, 64'h0);
    check_log(1, 64'h4);

    // Redirect before ack: stale response flushed.
    do_reset(2, 1'b1);
    expect_instr(64'h100, 32'h1300_0100);
    tick();
    redirect    = 1'b1;
    redirect_pc = 64'h100;
    tick();
    redirect = 1'b0;
    check("t3_flush_req", {63'h0, imem_req}, 64'h1);
    check("t3_flush_addr", imem_addr, 64'h0);
    check("t3_flush_valid0", {63'h0, instr_valid}, 64'h0);
    tick();
    check("t3_flush_valid1", {63'h0, instr_valid}, 64'h0);
    tick();
    check("t3_new_valid", {63'h0, instr_valid}, 64'h0);
    check("t3_new_addr", imem_addr, 64'h100);
    finish_test();
    check_log(0, 64'h0);
    check_log(1, 64'h100);

    // Redirect with ack, then redirect with instr_ready during HOLD.
    do_reset(0, 1'b1);
    expect_instr(64'h200, 32'h1300_0200);
    expect_instr(64'h300, 32'h1300_0300);
    tick();
    redirect    = 1'b1;
    redirect_pc = 64'h200;
    tick();
    redirect = 1'b0;
    check("t4_req", {63'h0, imem_req}, 64'h1);
    check("t4_addr", imem_addr, 64'h200);
    check("t4_valid", {63'h0, instr_valid}, 64'h0);
    wait_valid(10);
    tick();
    wait_valid(10);
    check("t4_hold_pc", pc, 64'h204);
    redirect    = 1'b1;
    redirect_pc = 64'h300;
    tick();
    redirect = 1'b0;
    check("t4_drop_valid", {63'h0, instr_valid}, 64'h0);
    check("t4_redir_addr", imem_addr, 64'h300);
    finish_test();
    check_log(2, 64'h204);
    check_log(3, 64'h300);

    // Misaligned redirect target.
    do_reset(0, 1'b1);
    expect_instr(64'h100, 32'h1300_0100);
    tick();
    redirect    = 1'b1;
    redirect_pc = 64'h103;
    tick();
    redirect = 1'b0;
    check("t5_mis_pulse", {63'h0, misaligned}, 64'h1);
    check("t5_aligned_addr", imem_addr, 64'h100);
    tick();
    check("t5_mis_clear", {63'h0, misaligned}, 64'h0);
    finish_test();
    check("t5_mis_count", 64'(mis_cnt), 64'h1);

    // PC wrap, then reset in the middle of a stalled request.
    do_reset(0, 1'b1);
    expect_instr(64'hFFFF_FFFF_FFFF_FFFC, 32'h1300_FFFC);
    expect_instr(64'h0, 32'hF800_0020);
    tick();
    redirect    = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect = 1'b0;
    check("t6_top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    wait_empty(20);
    tick();
    mem_stall   = 1'b1;
    instr_ready = 1'b0;
    tick();
    check("t6_stall_req", {63'h0, imem_req}, 64'h1);
    check("t6_stall_addr", imem_addr, 64'h4);
    #5;
    rst_n = 1'b0;
    #1;
    check("t6_async_req", {63'h0, imem_req}, 64'h0);
    check("t6_async_valid", {63'h0, instr_valid}, 64'h0);
    check("t6_async_addr", imem_addr, 64'h0);
    @(negedge clk);
    mem_stall   = 1'b0;
    instr_ready = 1'b1;
    rst_n       = 1'b1;
    expect_instr(64'h0, 32'hF800_0020);
    tick();
    check("t6_restart_req", {63'h0, imem_req}, 64'h1);
    check("t6_restart_addr", imem_addr, 64'h0);
    finish_test();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

endmodule
